// File: rtl/layer_pkg.sv
// Shared constants, state encoding and helpers for the per-layer input trackers.
package layer_pkg;

    localparam logic IDLE = 1'b0;
    localparam logic BUSY = 1'b1;

    typedef enum logic {
        ST_IDLE = IDLE,
        ST_BUSY = BUSY
    } state_e;

    // Default geometry of the layer this tracker family was first built for.
    localparam int L1_IMG_W     = 12;
    localparam int L1_IMG_H     = 12;
    localparam int L1_KERNEL    = 3;
    localparam int L1_BUF_ROWS  = 4;
    localparam int L1_READY_LAG = 1;
    localparam int L1_CNT_W     = 10;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/layer_input_tracker_sat_counter.sv
// Up-counter that saturates at MAX; clear wins over increment.
module sat_counter
    import layer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int MAX   = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q < WIDTH'(MAX))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/layer_input_tracker.sv
// Input-side flow tracker for one conv layer: counts incoming raster pixels, flags when the next
// output row of windows is available and throttles the producer to the line-buffer depth.
module layer_input_tracker
    import layer_pkg::*;
#(
    parameter int IMG_W     = L1_IMG_W,
    parameter int IMG_H     = L1_IMG_H,
    parameter int KERNEL    = L1_KERNEL,
    parameter int BUF_ROWS  = L1_BUF_ROWS,
    parameter int READY_LAG = L1_READY_LAG,
    parameter int CNT_W     = L1_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             conv_start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             row_done,
    output logic             win_ready,
    output logic [CNT_W-1:0] out_row,
    output logic             busy,
    output logic             done
);

    localparam int TOTAL = IMG_W * IMG_H;
    localparam int OUT_H = IMG_H - KERNEL + 1;
    localparam int TW    = CNT_W + 2;

    state_e           state_q;
    logic [CNT_W-1:0] pix_cnt_q;
    logic [CNT_W-1:0] out_row_q;

    logic             start_d;
    logic             accept_d;
    logic             row_inc_d;
    logic             img_done_d;
    logic             busy_d;
    logic [TW-1:0]    buf_lim_d;
    logic [TW-1:0]    win_thr_d;

    always_comb begin
        busy_d     = (state_q == ST_BUSY);
        start_d    = (state_q == ST_IDLE) && conv_start;
        accept_d   = in_valid && in_ready;
        row_inc_d  = busy_d && row_done;
        img_done_d = busy_d && (pix_cnt_q == CNT_W'(TOTAL)) && (out_row_q == CNT_W'(OUT_H));

        // Widened by two bits so (out_row + BUF_ROWS) * IMG_W cannot wrap for any legal out_row.
        buf_lim_d = (TW'(out_row_q) + TW'(BUF_ROWS)) * TW'(IMG_W);
        win_thr_d = (TW'(out_row_q) + TW'(KERNEL - 1)) * TW'(IMG_W) + TW'(KERNEL - READY_LAG);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (conv_start) state_q <= ST_BUSY;
                ST_BUSY: if (img_done_d) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    sat_counter #(
        .WIDTH (CNT_W),
        .MAX   (TOTAL)
    ) u_pix_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear_i (start_d),
        .inc_i   (accept_d),
        .cnt_o   (pix_cnt_q)
    );

    // Saturation at OUT_H is what makes surplus row_done pulses harmless.
    sat_counter #(
        .WIDTH (CNT_W),
        .MAX   (OUT_H)
    ) u_row_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear_i (start_d),
        .inc_i   (row_inc_d),
        .cnt_o   (out_row_q)
    );

    assign in_ready  = busy_d && (pix_cnt_q < CNT_W'(TOTAL)) && (TW'(pix_cnt_q) < buf_lim_d);
    assign win_ready = busy_d && (out_row_q < CNT_W'(OUT_H)) && (TW'(pix_cnt_q) >= win_thr_d);
    assign out_row   = out_row_q;
    assign busy      = busy_d;
    assign done      = img_done_d;

endmodule

// File: tb/tb_layer_input_tracker.sv
// Randomized scoreboard bench for layer_input_tracker: default 12x12 instance plus a 6x6/K5 instance.
module tb_layer_input_tracker;

    localparam int CW = 10;
    localparam int PW [2] = '{12, 6};
    localparam int PH [2] = '{12, 6};
    localparam int PK [2] = '{3, 5};
    localparam int PB [2] = '{4, 5};
    localparam int PL [2] = '{1, 0};

    typedef struct packed {
        logic          in_rdy;
        logic          win;
        logic          busy;
        logic          done;
        logic [CW-1:0] row;
    } exp_t;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n      [2];
    logic          conv_start [2];
    logic          in_valid   [2];
    logic          row_done   [2];
    logic          in_ready   [2];
    logic          win_ready  [2];
    logic          busy       [2];
    logic          done       [2];
    logic [CW-1:0] out_row    [2];

    layer_input_tracker #(
        .IMG_W(PW[0]), .IMG_H(PH[0]), .KERNEL(PK[0]), .BUF_ROWS(PB[0]), .READY_LAG(PL[0]), .CNT_W(CW)
    ) u_dut0 (
        .clk(clk), .rst(rst_n[0]), .conv_start(conv_start[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .row_done(row_done[0]), .win_ready(win_ready[0]),
        .out_row(out_row[0]), .busy(busy[0]), .done(done[0])
    );

    layer_input_tracker #(
        .IMG_W(PW[1]), .IMG_H(PH[1]), .KERNEL(PK[1]), .BUF_ROWS(PB[1]), .READY_LAG(PL[1]), .CNT_W(CW)
    ) u_dut1 (
        .clk(clk), .rst(rst_n[1]), .conv_start(conv_start[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .row_done(row_done[1]), .win_ready(win_ready[1]),
        .out_row(out_row[1]), .busy(busy[1]), .done(done[1])
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_seen [2];
    bit   m_busy [2];
    int   m_pix  [2];
    int   m_row  [2];
    bit   m_acc  [2];
    logic d_rst [2], d_start [2], d_vld [2], d_rd [2];
    exp_t sb_q0 [$];
    exp_t sb_q1 [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model: outputs follow directly from pixel/row counts of the image.
    function automatic exp_t model_out(int i);
        exp_t e;
        int total, outh;
        total    = PW[i] * PH[i];
        outh     = PH[i] - PK[i] + 1;
        e.busy   = m_busy[i];
        e.in_rdy = m_busy[i] && (m_pix[i] < total) && (m_pix[i] < (m_row[i] + PB[i]) * PW[i]);
        e.win    = m_busy[i] && (m_row[i] < outh)
                   && (m_pix[i] >= (m_row[i] + PK[i] - 1) * PW[i] + PK[i] - PL[i]);
        e.done   = m_busy[i] && (m_pix[i] == total) && (m_row[i] == outh);
        e.row    = CW'(m_row[i]);
        return e;
    endfunction

    task automatic model_update(int i, exp_t e);
        m_acc[i] = 1'b0;
        if (!d_rst[i]) begin
            m_busy[i] = 1'b0; m_pix[i] = 0; m_row[i] = 0;
        end else if (!m_busy[i]) begin
            if (d_start[i]) begin
                m_busy[i] = 1'b1; m_pix[i] = 0; m_row[i] = 0;
            end
        end else if (e.done) begin
            m_busy[i] = 1'b0;
        end else begin
            if (d_vld[i] && e.in_rdy) begin
                m_pix[i]++;
                m_acc[i] = 1'b1;
            end
            if (d_rd[i] && m_row[i] < PH[i] - PK[i] + 1) m_row[i]++;
        end
    endtask

    // One cycle: drive inputs after the edge, record what the DUT must show this cycle.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            rst_n[i]      = d_rst[i];
            conv_start[i] = d_start[i];
            in_valid[i]   = d_vld[i];
            row_done[i]   = d_rd[i];
            e = model_out(i);
            if (i == 0) sb_q0.push_back(e); else sb_q1.push_back(e);
            model_update(i, e);
        end
    endtask

    function automatic logic next_vld(int i, int pct);
        if (m_pix[i] >= PW[i] * PH[i]) return 1'b0;
        if (d_vld[i] && !m_acc[i]) return 1'b1;
        return ($urandom_range(0, 99) < pct);
    endfunction

    task automatic run_to_done(int i, int vpct, int rpct, int budget);
        int n;
        n = 0;
        while (m_busy[i] && n < budget) begin
            d_vld[i] = next_vld(i, vpct);
            d_rd[i]  = model_out(i).win && ($urandom_range(0, 99) < rpct);
            step();
            n++;
        end
        d_vld[i] = 1'b0;
        d_rd[i]  = 1'b0;
        step();
        chk("idle_after_image", busy[i], 1'b0);
        chk("win_low_after_image", win_ready[i], 1'b0);
    endtask

    task automatic restart(int i);
        d_rst[i] = 1'b0; step();
        d_rst[i] = 1'b1; step();
        d_start[i] = 1'b1; step();
        d_start[i] = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if ((i == 0 && sb_q0.size() > 0) || (i == 1 && sb_q1.size() > 0)) begin
                e = (i == 0) ? sb_q0.pop_front() : sb_q1.pop_front();
                chk(i == 0 ? "in_ready0" : "in_ready1", in_ready[i], e.in_rdy);
                chk(i == 0 ? "win_ready0" : "win_ready1", win_ready[i], e.win);
                chk(i == 0 ? "busy0" : "busy1", busy[i], e.busy);
                chk(i == 0 ? "done0" : "done1", done[i], e.done);
                chk(i == 0 ? "out_row0" : "out_row1", out_row[i], e.row);
            end
            if (done[i] === 1'b1) done_seen[i]++;
        end
    end

    initial begin
        int base, n;
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0; conv_start[i] = 1'b0; in_valid[i] = 1'b0; row_done[i] = 1'b0;
            d_rst[i] = 1'b0; d_start[i] = 1'b0; d_vld[i] = 1'b0; d_rd[i] = 1'b0;
            m_busy[i] = 1'b0; m_pix[i] = 0; m_row[i] = 0; m_acc[i] = 1'b0; done_seen[i] = 0;
        end
        step(); step();
        chk("reset_busy", busy[0], 1'b0);
        chk("reset_in_ready", in_ready[0], 1'b0);
        d_rst[0] = 1'b1; d_rst[1] = 1'b1;
        step();

        // Free-running producer, no row_done: stall at 48, then one row later at 60.
        d_start[0] = 1'b1; step(); d_start[0] = 1'b0;
        d_vld[0] = 1'b1;
        repeat (60) step();
        chk("stall48_in_ready", in_ready[0], 1'b0);
        chk("stall48_win_ready", win_ready[0], 1'b1);
        chk("stall48_out_row", out_row[0], 0);
        d_rd[0] = 1'b1; step(); d_rd[0] = 1'b0;
        repeat (20) step();
        chk("stall60_in_ready", in_ready[0], 1'b0);
        chk("stall60_out_row", out_row[0], 1);

        // Finish the image, then a surplus row_done must be ignored.
        base = done_seen[0];
        run_to_done(0, 70, 50, 3000);
        d_rd[0] = 1'b1; step(); d_rd[0] = 1'b0;
        step(); step();
        chk("row_saturates", out_row[0], 10);
        chk("one_done_img1", done_seen[0] - base, 1);

        // Accept and row_done together at pix 47, row 0.
        restart(0);
        n = 0;
        while (m_pix[0] != 47 && n < 200) begin
            d_vld[0] = 1'b1; step(); n++;
        end
        d_vld[0] = 1'b1; d_rd[0] = 1'b1; step();
        d_vld[0] = 1'b0; d_rd[0] = 1'b0; step();
        chk("same_cycle_in_ready", in_ready[0], 1'b1);
        chk("same_cycle_out_row", out_row[0], 1);
        run_to_done(0, 80, 60, 3000);

        // conv_start while busy is ignored; reset mid-image aborts without done.
        restart(0);
        n = 0;
        while (m_pix[0] != 70 && n < 500) begin
            d_vld[0] = next_vld(0, 100);
            d_rd[0]  = model_out(0).win && ($urandom_range(0, 99) < 40);
            step(); n++;
        end
        d_rd[0] = 1'b0; d_start[0] = 1'b1; step(); d_start[0] = 1'b0;
        d_vld[0] = 1'b0; step();
        chk("start_ignored_busy", busy[0], 1'b1);
        base = done_seen[0];
        d_rst[0] = 1'b0; step();
        d_rst[0] = 1'b1; step();
        chk("abort_busy", busy[0], 1'b0);
        chk("abort_in_ready", in_ready[0], 1'b0);
        chk("abort_win_ready", win_ready[0], 1'b0);
        chk("abort_out_row", out_row[0], 0);
        chk("abort_no_done", done_seen[0] - base, 0);
        d_start[0] = 1'b1; step(); d_start[0] = 1'b0;
        base = done_seen[0];
        run_to_done(0, 60, 50, 3000);
        step();
        chk("one_done_img_restart", done_seen[0] - base, 1);

        // Second geometry: 6x6, K=5, BUF_ROWS=5, no lag.
        d_start[1] = 1'b1; step(); d_start[1] = 1'b0;
        base = done_seen[1];
        run_to_done(1, 100, 100, 500);
        step();
        chk("one_done_6x6", done_seen[1] - base, 1);
        chk("final_row_6x6", out_row[1], 2);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
